uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmitter; mirror of the system UART receiver. Serialises one frame per accepted word:
//   start bit, 6-9 data bits LSB first, optional parity, 1-3 stop bits.
//   Frame format is runtime-configurable and matches the receiver's config inputs bit-for-bit.
//   Sits between the UART register block and the TXD pin.
// PARAMETERS
//   FIFO_DEPTH  4  words in transmit FIFO; power of 2, >=2; used only with UART_TX_FIFO_EN
// PORTS
//   clk_i          in   1  clock
//   rst_ni         in   1  reset, asynchronous, active-low
//   en             in   1  bit strobe; one pulse per bit period; tie 1 when clk_i runs at baud rate
//   data_i         in   9  word to send, right-aligned; bits above data_size ignored
//   tx_valid_i     in   1  data_i valid
//   tx_ready_o     out  1  buffer can accept; transfer on posedge when tx_valid_i & tx_ready_o
//   data_size_i    in   4  data bits per frame, legal 6..9
//   parity_size_i  in   1  1 = parity bit present
//   parity_type_i  in   1  0 = even, 1 = odd
//   stop_size_i    in   2  stop bits, legal 1..3
//   tx_o           out  1  serial line, idle high
//   busy_o         out  1  frame in progress (START..STOP)
//   tx_done_o      out  1  1-cycle pulse on the edge that ends the last stop bit
// BEHAVIOUR
//   Reset (async): tx_o=1, tx_ready_o=1, busy_o=0, tx_done_o=0; state IDLE; buffer/FIFO emptied.
//   Reset mid-frame: line returns high immediately; partial and pending words dropped; no tx_done_o.
//   FSM IDLE->START->DATA->[PARITY]->STOP->IDLE|START. State advances and tx_o changes only on
//     posedge with en=1; each bit is held exactly one strobe period.
//   IDLE: tx_o=1. Advance on en when a word is pending: pop word; latch data_size, parity_size,
//     parity_type, stop_size; tx_o=0 (START). Config changes mid-frame have no effect.
//   DATA: shift out LSB first; data_size bits; counter = size-1, down to 0.
//   PARITY (only if parity_size=1): bit = ^data[size-1:0] ^ parity_type (even: total ones even).
//   STOP: tx_o=1 for stop_size periods. On last: tx_done_o pulses. If a word is pending, go straight
//     to START (back-to-back, no idle gap); else IDLE.
//   Illegal config: data_size<6 or >9 sends 8 bits; stop_size=0 sends 1 stop bit.
//   Latency: accept at edge N; START drives on first en edge after N (>=1 cycle).
//   Accept and pop on same edge are legal; the buffer never over- or under-runs.
//   tx_ready_o is combinational from buffer state only; never depends on tx_valid_i.
// CONFIGURATION
//   UART_TX_FIFO_EN defined: FIFO_DEPTH-entry FIFO; tx_ready_o = !full. Simultaneous push and pop
//     when full is not allowed (ready=0); when empty, a push is not visible to the FSM until the
//     next cycle.
//   Undefined: single holding register. tx_ready_o=1 while empty. One word is queued while another
//     shifts; FIFO_DEPTH is ignored.
// STRUCTURE
//   Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), DATA_W=9, MIN_DATA=6,
//     MAX_DATA=9, parity-type constants PAR_EVEN=0, PAR_ODD=1.
//   Sub-module uart_tx_fifo (sync FIFO, valid/ready both sides), instantiated only under
//     UART_TX_FIFO_EN. The shifter and FSM stay in uart_tx.
// TESTING
//   8N1, en=1, send 0x55 -> tx_o 0,1,0,1,0,1,0,1,0,1 then idle 1; tx_done_o one pulse at 10th edge.
//   7 data, even parity, 2 stop, send 0x03 -> 0,1,1,0,0,0,0,0,0(par),1,1; odd type -> par=1.
//   9 data, no parity, 3 stop, 0x1FF -> start + nine 1s + three 1s; 13 bit periods.
//   en pulsing 1-in-16 -> each bit lasts exactly 16 clk; tx_o stable between strobes.
//   Two words back-to-back -> second START follows last stop bit with no idle gap; tx_ready_o
//     drops when full (1 word, or FIFO_DEPTH words with UART_TX_FIFO_EN).
//   Assert rst_ni mid-DATA -> tx_o=1 same cycle; after release no residual frame; tx_done_o stays 0.
//   Change data_size_i mid-frame -> current frame unaffected; next frame uses the new size.
//   Loopback into the system UART receiver with identical config -> data matches, receiver error=0.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   - uart_state_e : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   - DATA_W       : width of a data word (right-aligned, up to 9 bits)
//   - MIN_DATA / MAX_DATA : legal data-bit range; anything else sends DEF_DATA
//   - PAR_EVEN / PAR_ODD  : encodings of parity_type_i
//   Helper functions normalise illegal frame configuration and build the
//   data-bit mask used for parity.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DATA_W   = 9;
    localparam int unsigned MIN_DATA = 6;
    localparam int unsigned MAX_DATA = 9;
    localparam int unsigned DEF_DATA = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Out-of-range data sizes fall back to 8 data bits.
    function automatic logic [3:0] eff_data_size(input logic [3:0] size);
        if ((size < 4'(MIN_DATA)) || (size > 4'(MAX_DATA))) begin
            return 4'(DEF_DATA);
        end
        return size;
    endfunction

    // A stop size of zero still sends one stop bit.
    function automatic logic [1:0] eff_stop_size(input logic [1:0] size);
        return (size == 2'd0) ? 2'd1 : size;
    endfunction

    // Ones in the low 'size' bit positions.
    function automatic logic [DATA_W-1:0] data_mask(input logic [3:0] size);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (int'(size) > i);
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous FIFO feeding the UART transmitter. Only compiled when
//   UART_TX_FIFO_EN is defined; the default build uses a single holding
//   register inside uart_tx instead.
//
//   Handshake (both sides): a word moves on the rising clk_i edge where
//   valid and ready are both high. in_ready_o depends only on fill level,
//   out_valid_o only on fill level, so neither depends on the other side's
//   valid/ready in the same cycle.
//
//   Ports
//     clk_i, rst_ni          clock, asynchronous active-low reset (empties FIFO)
//     in_valid_i/in_data_i   write side
//     in_ready_o             not full
//     out_valid_o/out_data_o read side; out_data_o is the head word
//     out_ready_i            consumer takes the head word
//
//   A word written into an empty FIFO appears on out_valid_o one cycle later.
// -----------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready_o  = (cnt_q != FULL_CNT);
    assign out_valid_o = (cnt_q != '0);
    assign out_data_o  = mem_q[rptr_q];

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q] = in_data_i;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Each accepted word becomes one frame on tx_o:
//   start bit (0), 6..9 data bits LSB first, optional parity, 1..3 stop bits.
//   The frame format is sampled once, when the frame starts, so config
//   changes during a frame only affect later frames.
//
//   Build option UART_TX_FIFO_EN:
//     defined   - FIFO_DEPTH-entry FIFO (uart_tx_fifo) buffers words
//     undefined - single holding register; one word can wait while another
//                 is shifting; FIFO_DEPTH has no effect
//
//   Handshake: a word is taken on the rising clk_i edge where tx_valid_i and
//   tx_ready_o are both high. tx_ready_o reflects buffer occupancy only and
//   never looks at tx_valid_i; data_i must be stable while tx_valid_i is high.
//
//   Ports
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     en              bit strobe; the FSM and tx_o move only on edges with en=1
//     data_i          word to send (bits above the data size are ignored)
//     tx_valid_i      data_i valid
//     tx_ready_o      buffer can accept a word
//     data_size_i     data bits per frame (6..9, otherwise 8)
//     parity_size_i   1 = parity bit present
//     parity_type_i   0 = even, 1 = odd
//     stop_size_i     stop bits (1..3, 0 behaves as 1)
//     tx_o            serial line, idle high
//     busy_o          frame in progress
//     tx_done_o       one-cycle pulse after the edge that ends the last stop bit
//     dbg_state_o     current FSM state
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en,
    input  logic [DATA_W-1:0] data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [3:0]        data_size_i,
    input  logic              parity_size_i,
    input  logic              parity_type_i,
    input  logic [1:0]        stop_size_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              tx_done_o,
    output uart_state_e       dbg_state_o
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end

    // Word buffer between the register block and the shifter.
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic              take_word;   // FSM pops the head word this edge

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (tx_valid_i),
        .in_data_i   (data_i),
        .in_ready_o  (tx_ready_o),
        .out_valid_o (buf_valid),
        .out_data_o  (buf_data),
        .out_ready_i (take_word)
    );
`else
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              hold_push;

    assign tx_ready_o = !hold_valid_q;
    assign hold_push  = tx_valid_i & tx_ready_o;

    // Push only when empty and pop only when full, so both never coincide.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (take_word) begin
            hold_valid_d = 1'b0;
        end
        if (hold_push) begin
            hold_d       = data_i;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign buf_valid = hold_valid_q;
    assign buf_data  = hold_q;
`endif

    // Frame state.
    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;    // data bits left after the one on the line
    logic [1:0]        stop_cnt_q, stop_cnt_d;  // stop bits left after the one on the line
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    // Values loaded when a new frame begins, taken from the live config.
    logic [3:0]        new_size;
    logic              new_par_bit;
    logic [1:0]        new_stop;

    assign new_size    = eff_data_size(data_size_i);
    assign new_stop    = eff_stop_size(stop_size_i);
    assign new_par_bit = (^(buf_data & data_mask(new_size))) ^ (parity_type_i == PAR_ODD);

    // A word is consumed from IDLE, or from the final stop bit so the next
    // frame starts with no idle gap.
    assign take_word = en && buf_valid &&
                       ((state_q == IDLE) || ((state_q == STOP) && (stop_cnt_q == 2'd0)));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                end
                START: begin
                    // First data bit goes out as the start bit ends.
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
                DATA: begin
                    if (bit_cnt_q == 4'd0) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (stop_cnt_q == 2'd0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase

            if (take_word) begin
                state_d    = START;
                tx_d       = 1'b0;
                shift_d    = buf_data;
                bit_cnt_d  = new_size - 4'd1;
                stop_cnt_d = new_stop - 2'd1;
                par_en_d   = parity_size_i;
                par_bit_d  = new_par_bit;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx_o        = tx_q;
    assign busy_o      = (state_q != IDLE);
    assign tx_done_o   = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
  import uart_pkg::*;

  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  localparam int M_IDLE = 0;
  localparam int M_DATA = 1;
  localparam int M_PAR  = 2;
  localparam int M_STOP = 3;
  localparam int M_END  = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en = 1'b0;
  logic [8:0]  data_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [3:0]  data_size_i = 4'd8;
  logic        parity_size_i = 1'b0;
  logic        parity_type_i = 1'b0;
  logic [1:0]  stop_size_i = 2'd1;
  logic        tx_o;
  logic        busy_o;
  logic        tx_done_o;
  uart_state_e dbg_state;

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_period = 1;
  int en_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      en_cnt++;
      if (en_cnt >= en_period) begin
        en = 1'b1;
        en_cnt = 0;
      end else begin
        en = 1'b0;
      end
    end
  end

  uart_tx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .en            (en),
    .data_i        (data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .data_size_i   (data_size_i),
    .parity_size_i (parity_size_i),
    .parity_type_i (parity_type_i),
    .stop_size_i   (stop_size_i),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .tx_done_o     (tx_done_o),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [3:0] s);
    return (s >= 4'd6 && s <= 4'd9) ? int'(s) : 8;
  endfunction

  function automatic int ref_stop(input logic [1:0] s);
    return (s == 2'd0) ? 1 : int'(s);
  endfunction

  function automatic logic [8:0] ref_mask(input logic [8:0] w, input int size);
    logic [8:0] r = '0;
    for (int i = 0; i < size; i++) r[i] = w[i];
    return r;
  endfunction

  // Parity bit that makes total ones even (odd=0) or odd (odd=1).
  function automatic logic ref_parity(input logic [8:0] w, input int size, input logic odd);
    int ones = 0;
    for (int i = 0; i < size; i++) ones += int'(w[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // ---------------- scoreboard: line receiver ----------------
  logic [8:0] exp_q[$];
  int         m_phase = M_IDLE;
  int         m_size, m_stop, m_bits, m_stops;
  logic       m_par_en, m_ptype, m_par_bit;
  logic [8:0] m_word;
  logic       prev_tx = 1'b1;
  int gap = 0, last_gap = 0, frames_done = 0, b2b_cnt = 0;
  int stray_done = 0, unstable = 0, bad_stop = 0;
  int start_cyc = 0, end_cyc = 0, acc_cyc = 0;

  task automatic mon_start();
    m_size   = ref_size(data_size_i);
    m_stop   = ref_stop(stop_size_i);
    m_par_en = parity_size_i;
    m_ptype  = parity_type_i;
    m_bits   = 0;
    m_stops  = 0;
    m_word   = '0;
    last_gap = gap;
    gap      = 0;
    start_cyc = cyc;
    m_phase  = M_DATA;
    check_eq("busy_at_start", busy_o, 1);
  endtask

  task automatic mon_finish();
    logic [8:0] w;
    frames_done++;
    check_eq("frame_expected", (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check_eq("data", m_word, ref_mask(w, m_size));
      if (m_par_en) check_eq("parity", m_par_bit, ref_parity(w, m_size, m_ptype));
      check_eq("stop_bits", bad_stop, 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_ni) begin
        m_phase = M_IDLE;
        prev_tx = tx_o;
        gap = 0;
        continue;
      end
      if (!en) begin
        if (tx_o !== prev_tx) unstable++;
        if (tx_done_o !== 1'b0) stray_done++;
        prev_tx = tx_o;
        continue;
      end
      if (m_phase != M_END && tx_done_o !== 1'b0) stray_done++;
      case (m_phase)
        M_IDLE: begin
          if (tx_o === 1'b0) mon_start();
          else gap++;
        end
        M_DATA: begin
          m_word[m_bits] = tx_o;
          m_bits++;
          if (m_bits == m_size) m_phase = m_par_en ? M_PAR : M_STOP;
        end
        M_PAR: begin
          m_par_bit = tx_o;
          m_phase = M_STOP;
        end
        M_STOP: begin
          if (tx_o !== 1'b1) bad_stop++;
          m_stops++;
          if (m_stops == m_stop) m_phase = M_END;
        end
        default: begin
          check_eq("tx_done", tx_done_o, 1);
          end_cyc = cyc;
          mon_finish();
          if (tx_o === 1'b0) begin
            b2b_cnt++;
            mon_start();
          end else begin
            m_phase = M_IDLE;
            gap = 1;
            check_eq("busy_after_frame", busy_o, 0);
          end
        end
      endcase
      prev_tx = tx_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input int size, input logic par, input logic ptype, input int stop);
    @(negedge clk);
    data_size_i   = 4'(size);
    parity_size_i = par;
    parity_type_i = ptype;
    stop_size_i   = 2'(stop);
  endtask

  task automatic send_word(input logic [8:0] w);
    int n = 0;
    @(negedge clk);
    data_i = w;
    tx_valid_i = 1'b1;
    while (tx_ready_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_in_time", (n < 2000), 1);
    if (n < 2000) begin
      @(posedge clk);
      exp_q.push_back(w);
      #1;
      acc_cyc = cyc;
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && m_phase == M_IDLE && busy_o === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_in_time", (n < budget), 1);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("phase_in_time", (n < budget), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int b0, fd, sd;
    logic [8:0] w;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx_o, 1);
    check_eq("rst_ready", tx_ready_o, 1);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", tx_done_o, 0);
    check_eq("rst_state", dbg_state, IDLE);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1, en always high, 0x55
    en_period = 1;
    set_cfg(8, 1'b0, 1'b0, 1);
    send_word(9'h055);
    wait_phase(M_DATA, 100);
    check_eq("start_latency", start_cyc - acc_cyc, 1);
    wait_idle(200);
    check_eq("len_8n1", end_cyc - start_cyc, 10);

    // 7 data, even then odd parity, 2 stop, 0x03
    set_cfg(7, 1'b1, PAR_EVEN, 2);
    send_word(9'h003);
    wait_idle(200);
    check_eq("len_7e2", end_cyc - start_cyc, 11);
    set_cfg(7, 1'b1, PAR_ODD, 2);
    send_word(9'h003);
    wait_idle(200);
    check_eq("len_7o2", end_cyc - start_cyc, 11);

    // 9 data, no parity, 3 stop, all ones
    set_cfg(9, 1'b0, 1'b0, 3);
    send_word(9'h1FF);
    wait_idle(200);
    check_eq("len_9n3", end_cyc - start_cyc, 13);

    // slow strobe: 1 in 16 clocks
    en_period = 16;
    set_cfg(8, 1'b0, 1'b0, 1);
    send_word(9'($urandom_range(0, 255)));
    wait_idle(1000);
    check_eq("len_slow", end_cyc - start_cyc, 160);

    // back-to-back and buffer full
    en_period = 2;
    b0 = b2b_cnt;
    send_word(9'($urandom_range(0, 511)));
    wait_phase(M_DATA, 100);
    for (int i = 0; i < CAP; i++) send_word(9'($urandom_range(0, 511)));
    check_eq("ready_full", tx_ready_o, 0);
    wait_idle(2000);
    check_eq("b2b_frames", b2b_cnt - b0, CAP);
    check_eq("ready_after_drain", tx_ready_o, 1);

    // config change mid-frame: current frame keeps 8 bits, next uses 6
    set_cfg(8, 1'b0, 1'b0, 1);
    send_word(9'h03C);
    wait_phase(M_DATA, 100);
    send_word(9'h0A5);
    set_cfg(6, 1'b0, 1'b0, 1);
    wait_idle(2000);
    check_eq("len_6n1_after_change", end_cyc - start_cyc, 16);

    // reset during data bits with a word pending
    en_period = 1;
    set_cfg(8, 1'b0, 1'b0, 1);
    send_word(9'h000);
    send_word(9'h00F);
    wait_phase(M_DATA, 100);
    @(negedge clk);
    check_eq("line_low_before_rst", tx_o, 0);
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_tx", tx_o, 1);
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_ready", tx_ready_o, 1);
    check_eq("midrst_done", tx_done_o, 0);
    exp_q.delete();
    fd = frames_done;
    sd = stray_done;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("no_residual_frame", frames_done - fd, 0);
    check_eq("no_done_after_rst", stray_done - sd, 0);
    check_eq("idle_after_rst_tx", tx_o, 1);
    check_eq("idle_after_rst_busy", busy_o, 0);

    // randomized frames, including illegal sizes and stop=0
    for (int k = 0; k < 30; k++) begin
      en_period = $urandom_range(1, 3);
      set_cfg($urandom_range(4, 11), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
      w = 9'($urandom_range(0, 511));
      send_word(w);
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_idle(5000);

    check_eq("stray_done", stray_done, 0);
    check_eq("unstable_line", unstable, 0);
    check_eq("pending_frames", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
